// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file read-port arbiter.
// Holds default geometry, FSM state encoding and the fixed requester slots.
package regfile_port_arbiter_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int AW_DEF       = 5;
    localparam int DW_DEF       = 32;
    localparam int MAX_LOCK_DEF = 32;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Requester slots: ID stage is fixed-priority slot 0.
    localparam int REQ_ID  = 0;
    localparam int REQ_DBG = 1;
    localparam int REQ_EXC = 2;

endpackage

// File: rtl/regfile_port_arbiter_rr_pick.sv
// Round-robin picker for requesters 1..NREQ-1 (combinational).
// Ports:
//   req_rr  in  NREQ-1  bit k = request from requester k+1
//   rr_ptr  in  PW      requester index of the last round-robin winner (1..NREQ-1)
//   win_rr  out NREQ-1  one-hot winner, bit k = requester k+1
module regfile_port_arbiter_rr_pick
    import regfile_port_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-2:0] req_rr,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-2:0] win_rr
);

    int   last_pos_s;
    logic found_s;

    // Two passes: first the slots after the last winner, then wrap from slot 1.
    always_comb begin
        win_rr     = '0;
        found_s    = 1'b0;
        last_pos_s = int'(rr_ptr) - 1;
        for (int k = 0; k < NREQ - 1; k++) begin
            if (!found_s && req_rr[k] && (k > last_pos_s)) begin
                win_rr[k] = 1'b1;
                found_s   = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        for (int k = 0; k < NREQ - 1; k++) begin
            if (!found_s && req_rr[k]) begin
                win_rr[k] = 1'b1;
                found_s   = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one register-file read port among NREQ requesters.
// Requester 0 has fixed priority, the rest are served round-robin; a
// requester holding lock keeps the port for a burst of up to MAX_LOCK grants.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   req, lock  per-requester request / burst-lock
//   addr       packed register addresses, requester i at [i*AW +: AW]
//   gnt        one-hot registered grant
//   sel        registered read-mux select
//   rdata_in   read-mux output (combinational from sel)
//   rdata      registered read data, rvalid one-hot owner tag
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]    gnt,
    output logic [AW-1:0]      sel,
    input  logic [DW-1:0]      rdata_in,
    output logic [DW-1:0]      rdata,
    output logic [NREQ-1:0]    rvalid
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [AW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;

    logic [NREQ-2:0] rr_win_s;
    logic [PW-1:0]   rr_idx_s;
    logic            own_req_s;
    logic            own_lock_s;
    logic            arb_mode_s;
    logic [PW-1:0]   win_idx_s;
    logic            win_vld_s;
    logic            win_lock_s;
    logic [CW-1:0]   cnt_inc_s;

    regfile_port_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req_rr (req[NREQ-1:1]),
        .rr_ptr (rr_ptr_q),
        .win_rr (rr_win_s)
    );

    // Encode the round-robin winner and look up the lock owner's req/lock bits.
    always_comb begin
        rr_idx_s   = '0;
        own_req_s  = 1'b0;
        own_lock_s = 1'b0;
        for (int k = 0; k < NREQ - 1; k++) begin
            rr_idx_s = rr_win_s[k] ? PW'(k + 1) : rr_idx_s;
        end
        for (int k = 0; k < NREQ; k++) begin
            own_req_s  = (owner_q == PW'(k)) ? req[k]  : own_req_s;
            own_lock_s = (owner_q == PW'(k)) ? lock[k] : own_lock_s;
        end
    end

    // A locked owner that dropped lock hands the decision back to normal arbitration.
    assign arb_mode_s = (state_q == ARB) || !own_lock_s;
    assign cnt_inc_s  = (lock_cnt_q == CW'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + CW'(1);

    // Arbitration FSM: pick a winner, update pointer/lock state, form grant and select.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        gnt_d      = '0;
        sel_d      = sel_q;
        win_idx_s  = '0;
        win_vld_s  = 1'b0;
        win_lock_s = 1'b0;

        if (arb_mode_s) begin
            state_d    = ARB;
            lock_cnt_d = '0;
            if (req[0]) begin
                // ID stage wins; round-robin pointer is left alone.
                win_idx_s = '0;
                win_vld_s = 1'b1;
            end else if (|rr_win_s) begin
                win_idx_s = rr_idx_s;
                win_vld_s = 1'b1;
                rr_ptr_d  = rr_idx_s;
            end else begin
                win_vld_s = 1'b0;
            end
            for (int k = 0; k < NREQ; k++) begin
                win_lock_s = (win_idx_s == PW'(k)) ? lock[k] : win_lock_s;
            end
            if (win_vld_s && win_lock_s && (MAX_LOCK > 1)) begin
                state_d    = LOCKED;
                owner_d    = win_idx_s;
                lock_cnt_d = CW'(1);
            end else begin
                owner_d = owner_q;
            end
        end else begin
            if (own_req_s) begin
                win_idx_s  = owner_q;
                win_vld_s  = 1'b1;
                lock_cnt_d = cnt_inc_s;
                // The grant reaching MAX_LOCK ends the burst; the owner re-competes next cycle.
                if (cnt_inc_s == CW'(MAX_LOCK)) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else begin
                    state_d = LOCKED;
                end
            end else begin
                // Gap in a locked burst: no grant, lock kept.
                win_vld_s = 1'b0;
            end
        end

        for (int k = 0; k < NREQ; k++) begin
            if (win_vld_s && (win_idx_s == PW'(k))) begin
                gnt_d[k] = 1'b1;
                sel_d    = addr[k*AW +: AW];
            end else begin
                gnt_d[k] = gnt_d[k];
            end
        end
    end

    // Read return path: rvalid is the grant one cycle later, rdata only moves with it.
    always_comb begin
        rvalid_d = gnt_q;
        if (|gnt_q) begin
            rdata_d = rdata_in;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            rr_ptr_q   <= PW'(NREQ - 1);
            owner_q    <= '0;
            lock_cnt_q <= '0;
            gnt_q      <= '0;
            sel_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign gnt    = gnt_q;
    assign sel    = sel_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed self-checking bench for regfile_port_arbiter (NREQ=4, AW=5, DW=32).
module tb_regfile_port_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [19:0] addr;
    logic [3:0]  gnt;
    logic [4:0]  sel;
    logic [31:0] rdata_in;
    logic [31:0] rdata;
    logic [3:0]  rvalid;

    int errors = 0;
    int checks = 0;

    // Register file contents: r9 holds DEADBEEF, others a tagged pattern.
    function automatic logic [31:0] reg_val(input logic [4:0] a);
        if (a == 5'd9) return 32'hDEADBEEF;
        return {8'hC0, 19'h0, a};
    endfunction

    assign rdata_in = reg_val(sel);

    regfile_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .addr     (addr),
        .gnt      (gnt),
        .sel      (sel),
        .rdata_in (rdata_in),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst  = 1'b1;
        req  = 4'b0000;
        lock = 4'b0000;
        addr = 20'h0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
        checks++; if (sel !== 5'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        // Build up live outputs, then reset asynchronously mid-cycle.
        addr[5 +: 5] = 5'd9;
        req = 4'b0010;
        step();
        step();
        checks++; if (rvalid !== 4'b0010) begin errors++; $display("FAIL pre_reset_rvalid got=%b exp=0010", rvalid); end
        req = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL async_gnt got=%b exp=0000", gnt); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL async_rvalid got=%b exp=0000", rvalid); end
        checks++; if (sel !== 5'd0) begin errors++; $display("FAIL async_sel got=%0d exp=0", sel); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL async_rdata got=%h exp=0", rdata); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        addr[5 +: 5] = 5'd9;
        req = 4'b0010;
        step();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got=%b exp=0010", gnt); end
        checks++; if (sel !== 5'd9) begin errors++; $display("FAIL single_sel got=%0d exp=9", sel); end
        req = 4'b0000;
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_drop got=%b exp=0000", gnt); end
        checks++; if (rvalid !== 4'b0010) begin errors++; $display("FAIL single_rvalid got=%b exp=0010", rvalid); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata); end
        step();
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata_hold got=%h exp=deadbeef", rdata); end
    endtask

    task automatic test_priority;
        logic [3:0] exp_rr [6];
        exp_rr = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int i = 0; i < 4; i++) addr[i*5 +: 5] = 5'(i + 3);
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL prio_gnt[%0d] got=%b exp=0001", i, gnt); end
        end
        req = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (gnt !== exp_rr[i]) begin errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, gnt, exp_rr[i]); end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_burst;
        logic [3:0] exp_g;
        logic [3:0] prev_g;
        do_reset();
        prev_g = 4'b0000;
        req  = 4'b0100;
        lock = 4'b0100;
        addr[10 +: 5] = 5'd0;
        for (int c = 0; c < 34; c++) begin
            step();
            exp_g = (c < 32) ? 4'b0100 : 4'b0001;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL burst_gnt[%0d] got=%b exp=%b", c, gnt, exp_g); end
            checks++; if (rvalid !== prev_g) begin errors++; $display("FAIL burst_rvalid[%0d] got=%b exp=%b", c, rvalid, prev_g); end
            if (c < 32) begin
                checks++; if (sel !== 5'(c)) begin errors++; $display("FAIL burst_sel[%0d] got=%0d exp=%0d", c, sel, c); end
            end
            if (c >= 1 && c <= 32) begin
                checks++; if (rdata !== reg_val(5'(c - 1))) begin errors++; $display("FAIL burst_rdata[%0d] got=%h exp=%h", c, rdata, reg_val(5'(c - 1))); end
            end
            prev_g = exp_g;
            req[0] = 1'b1;
            addr[10 +: 5] = 5'(c + 1);
        end
        req  = 4'b0000;
        lock = 4'b0000;
        step();
    endtask

    task automatic test_lock_gap;
        do_reset();
        addr[15 +: 5] = 5'd20;
        addr[5 +: 5]  = 5'd4;
        req  = 4'b1000;
        lock = 4'b1000;
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL gap_enter got=%b exp=1000", gnt); end
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL gap_second got=%b exp=1000", gnt); end
        req = 4'b0010;
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL gap_hole1 got=%b exp=0000", gnt); end
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL gap_hole2 got=%b exp=0000", gnt); end
        req = 4'b1010;
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL gap_resume got=%b exp=1000", gnt); end
        checks++; if (sel !== 5'd20) begin errors++; $display("FAIL gap_sel got=%0d exp=20", sel); end
        req  = 4'b0010;
        lock = 4'b0000;
        step();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL gap_release got=%b exp=0010", gnt); end
        checks++; if (sel !== 5'd4) begin errors++; $display("FAIL gap_release_sel got=%0d exp=4", sel); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_burst;
        do_reset();
        addr[10 +: 5] = 5'd7;
        req  = 4'b0100;
        lock = 4'b0100;
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rstb_gnt got=%b exp=0100", gnt); end
        req  = 4'b0000;
        lock = 4'b0000;
        rst  = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rstb_gnt_clear got=%b exp=0000", gnt); end
        step();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rstb_rvalid got=%b exp=0000", rvalid); end
        rst = 1'b0;
        req = 4'b0110;
        step();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rstb_first got=%b exp=0010", gnt); end
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rstb_second got=%b exp=0100", gnt); end
        req = 4'b0000;
        step();
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        lock = 4'b0000;
        addr = 20'h0;
        test_reset();
        test_single();
        test_priority();
        test_burst();
        test_lock_gap();
        test_reset_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
